// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_feeder
//  Purpose  : Frame-aligned sample feeder and result collector for fir_filter.
//  Revision : 1.0  initial release
// ============================================================================
module fir_sample_feeder #(
    parameter int FRAME_LEN  = 20,
    parameter int FIFO_DEPTH = 8,
    parameter int DISCARD    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      filt_sample,
    output logic                            filt_ready,
    input  logic [7:0]                      filt_out,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    output logic                            underrun,
    input  logic                            clr_status
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_CNT_W = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN);
    localparam int c_DIS_W = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_CNT_W-1:0]   r_frame_cnt;
    logic [c_DIS_W-1:0]   r_discard_cnt;
    logic                 r_stop_req;
    logic [7:0]           r_filt_sample;
    logic                 r_filt_ready;
    logic [7:0]           r_out_data;
    logic                 r_out_valid;
    logic                 r_underrun;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_boundary;
    logic                 w_stopping;
    logic                 w_load;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_capture;
    logic [7:0]           w_next_sample;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_boundary = (r_state == ST_RUN) && (r_frame_cnt == c_CNT_W'(FRAME_LEN - 1));
    assign w_stopping = r_stop_req || !en;
    // A new sample is loaded on the start edge and on every boundary that is not the last.
    assign w_load     = ((r_state == ST_IDLE) && en) || (w_boundary && !w_stopping);
    assign w_pop      = w_load && !w_empty;
    assign w_push     = in_valid && !w_full;
    assign w_capture  = (r_state != ST_IDLE) && (r_frame_cnt == '0);
    assign w_next_sample = w_pop ? r_mem[r_rd_ptr] : 8'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_frame_cnt   <= '0;
            r_discard_cnt <= c_DIS_W'(DISCARD);
            r_stop_req    <= 1'b0;
            r_filt_sample <= 8'd0;
            r_filt_ready  <= 1'b0;
            r_out_data    <= 8'd0;
            r_out_valid   <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            // The filter publishes its result on the boundary edge; take it one cycle later.
            if (w_capture) begin
                r_out_data <= filt_out;
                if (r_discard_cnt == '0) begin
                    r_out_valid <= 1'b1;
                end else begin
                    r_discard_cnt <= r_discard_cnt - 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state       <= ST_RUN;
                        r_filt_ready  <= 1'b1;
                        r_frame_cnt   <= '0;
                        r_discard_cnt <= c_DIS_W'(DISCARD);
                        r_stop_req    <= 1'b0;
                        r_filt_sample <= w_next_sample;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_boundary) begin
                        r_frame_cnt <= '0;
                        if (w_stopping) begin
                            r_state       <= ST_DRAIN;
                            r_filt_ready  <= 1'b0;
                            r_filt_sample <= 8'd0;
                        end else begin
                            r_filt_sample <= w_next_sample;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_filt_ready <= 1'b0;
                end
            endcase

            if (w_load && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clr_status) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign in_ready    = !w_full;
    assign fifo_level  = r_level;
    assign filt_sample = r_filt_sample;
    assign filt_ready  = r_filt_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_sample_feeder
//  Purpose  : Directed plus randomized bench for fir_sample_feeder with a
//             queue-based reference model and a stand-in filter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_sample_feeder;

    localparam int FRAME_LEN  = 20;
    localparam int FIFO_DEPTH = 8;
    localparam int DISCARD    = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] fifo_level;
    logic [7:0] filt_sample;
    logic       filt_ready;
    logic [7:0] filt_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       underrun;
    logic       clr_status;

    fir_sample_feeder #(
        .FRAME_LEN (FRAME_LEN),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DISCARD   (DISCARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .filt_sample(filt_sample),
        .filt_ready (filt_ready),
        .filt_out   (filt_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .underrun   (underrun),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: what the feeder should be showing, derived from frame position.
    logic [7:0] q[$];
    bit         m_run, m_drain, m_stop;
    int         m_pos, m_disc;
    logic [7:0] m_sample, m_out_data, m_prev_latch;
    bit         m_ready, m_valid, m_ur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_drain = 0; m_stop = 0;
        m_pos = 0; m_disc = DISCARD;
        m_sample = 8'd0; m_out_data = 8'd0;
        m_ready = 0; m_valid = 0; m_ur = 0;
    endtask

    task automatic check_all();
        chk("filt_ready",  filt_ready,  m_ready);
        chk("filt_sample", filt_sample, m_sample);
        chk("out_valid",   out_valid,   m_valid);
        chk("out_data",    out_data,    m_out_data);
        chk("in_ready",    in_ready,    q.size() < FIFO_DEPTH);
        chk("fifo_level",  fifo_level,  q.size());
        chk("underrun",    underrun,    m_ur);
    endtask

    // One clock: predict from current inputs, advance, drive the stand-in filter, compare.
    task automatic step();
        int         size_pre;
        bit         load, boundary, ur_set, nxt_valid;
        logic [7:0] latched;
        size_pre  = q.size();
        load      = 0;
        boundary  = 0;
        ur_set    = 0;
        nxt_valid = 0;
        latched   = m_sample;
        if ((m_run || m_drain) && m_pos == 0) begin
            m_out_data = filt_out;
            if (m_disc == 0) nxt_valid = 1;
            else m_disc--;
        end
        if (!m_run && !m_drain) begin
            if (en) begin
                m_run = 1; m_stop = 0; m_pos = 0; m_disc = DISCARD; m_ready = 1; load = 1;
            end
        end else if (m_drain) begin
            m_drain = 0;
        end else begin
            if (!en) m_stop = 1;
            if (m_pos == FRAME_LEN - 1) begin
                boundary = 1;
                m_pos = 0;
                if (m_stop) begin
                    m_run = 0; m_drain = 1; m_ready = 0; m_sample = 8'd0;
                end else begin
                    load = 1;
                end
            end else begin
                m_pos++;
            end
        end
        if (load) begin
            if (size_pre > 0) m_sample = q.pop_front();
            else begin m_sample = 8'd0; ur_set = 1; end
        end
        if (in_valid && size_pre < FIFO_DEPTH) q.push_back(in_data);
        if (ur_set) m_ur = 1;
        else if (clr_status) m_ur = 0;
        m_valid = nxt_valid;
        @(posedge clk);
        #1;
        if (boundary) begin
            filt_out     = latched - m_prev_latch;
            m_prev_latch = latched;
        end
        check_all();
    endtask

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'd0; clr_status = 1'b0;
        filt_out = 8'd0; m_prev_latch = 8'd0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Three queued samples stream out one per frame.
        in_valid = 1'b1;
        in_data = 8'd3;   step();
        in_data = 8'd5;   step();
        in_data = 8'hFF;  step();
        in_valid = 1'b0;
        chk("t1_level3", fifo_level, 3);
        en = 1'b1; step();
        chk("t1_first", filt_sample, 8'd3);
        chk("t1_level2", fifo_level, 2);
        chk("t1_ready", filt_ready, 1'b1);
        repeat (19) step();
        chk("t1_hold", filt_sample, 8'd3);
        step();
        chk("t1_second", filt_sample, 8'd5);
        chk("t1_level1", fifo_level, 1);
        repeat (20) step();
        chk("t1_third", filt_sample, 8'hFF);
        chk("t1_level0", fifo_level, 0);
        repeat (25) step();
        en = 1'b0;
        repeat (40) step();
        chk("t1_idle_ready", filt_ready, 1'b0);
        chk("t1_idle_sample", filt_sample, 8'd0);

        // Underrun clear, then set and clear on the same edge.
        chk("t3_ur_set", underrun, 1'b1);
        clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("t3_ur_clr", underrun, 1'b0);
        en = 1'b1; clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("t3_ur_setwins", underrun, 1'b1);
        chk("t3_zero", filt_sample, 8'd0);
        en = 1'b0;
        repeat (25) step();

        // Overfill, then run with constant push pressure.
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'($urandom);
            step();
        end
        chk("t4_full_level", fifo_level, 8);
        chk("t4_full_ready", in_ready, 1'b0);
        en = 1'b1;
        repeat (45) step();
        in_valid = 1'b0;
        guard = 0;
        while (m_pos != 7 && guard < 40) begin step(); guard++; end
        chk("t5_reach_pos7", m_pos, 7);
        en = 1'b0;
        repeat (12) step();
        chk("t5_ready_to_end", filt_ready, 1'b1);
        step();
        chk("t5_ready_drop", filt_ready, 1'b0);
        chk("t5_sample_zero", filt_sample, 8'd0);
        step();
        chk("t5_final_valid", out_valid, 1'b1);
        step();

        // Randomized traffic.
        for (int i = 0; i < 1600; i++) begin
            int rate;
            rate = (i < 800) ? 12 : 4;
            in_valid   = ($urandom_range(0, 99) < rate);
            in_data    = 8'($urandom);
            clr_status = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            step();
        end
        clr_status = 1'b0;

        // Asynchronous reset in the middle of a frame.
        en = 1'b1; in_valid = 1'b1;
        guard = 0;
        while (!(m_run && m_pos == 10) && guard < 100) begin
            in_data = 8'($urandom);
            step();
            guard++;
        end
        chk("t6_reach_pos10", m_pos, 10);
        in_valid = 1'b0; en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ready_async", filt_ready, 1'b0);
        chk("t6_level_async", fifo_level, 0);
        chk("t6_valid_async", out_valid, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_all();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
